split_6_enum: RTL and testbench

- Sequential stimulus generator and witness collector for the var_11/var_16/var_27 constraint checker.
- Sweeps the full 15-bit joint assignment space and drives each candidate onto the checker's var_* inputs.
- Samples the checker's x output and reports the first satisfying assignment and the total solution count.
- Sits beside the combinational checker as its initiator: used in solver cross-check benches and as on-chip brute-force reference.

---
 rtl/split_6_enum_if.sv | 32 +++
 rtl/split_6_enum.sv | 162 ++++++++++++++++
 tb/tb_split_6_enum.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/split_6_enum_if.sv
// Bus between the brute-force sweep generator and its environment:
// sweep control, candidate fields to the checker, checker result and sweep results.
interface split_6_enum_if #(
  parameter int W11 = 4,
  parameter int W16 = 4,
  parameter int W27 = 7
);
  localparam int IW = W11 + W16 + W27;

  logic          start;
  logic          stop_on_first;
  logic          abort;
  logic [W11-1:0] var_11;
  logic [W16-1:0] var_16;
  logic [W27-1:0] var_27;
  logic          x;
  logic          busy;
  logic          done;
  logic          found;
  logic [IW-1:0] first_idx;
  logic [IW:0]   sol_count;

  modport master (
    input  start, stop_on_first, abort, x,
    output var_11, var_16, var_27, busy, done, found, first_idx, sol_count
  );

  modport slave (
    output start, stop_on_first, abort, x,
    input  var_11, var_16, var_27, busy, done, found, first_idx, sol_count
  );
endinterface

// File: rtl/split_6_enum.sv
// Sweeps every {var_27, var_16, var_11} candidate through an external checker,
// recording the first satisfying index and the number of satisfying candidates.
module split_6_enum #(
  parameter int W11       = 4,
  parameter int W16       = 4,
  parameter int W27       = 7,
  parameter int CHECK_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  split_6_enum_if.master bus
);
  localparam int              IW       = W11 + W16 + W27;
  localparam logic [1:0]      LAT_LOAD = 2'(CHECK_LAT - 1);
  localparam logic [IW-1:0]   IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]   IDX_LAST = {IW{1'b1}};
  localparam logic [IW:0]     CNT_ONE  = {{IW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [IW-1:0] index_r;
  logic [1:0]    lat_r;
  logic          stop_r;
  logic          busy_r;
  logic          done_r;
  logic          found_r;
  logic [IW-1:0] first_r;
  logic [IW:0]   count_r;
  logic [W11-1:0] v11_r;
  logic [W16-1:0] v16_r;
  logic [W27-1:0] v27_r;

  logic clear_s;
  logic drive_s;
  logic wait_s;
  logic hit_s;
  logic advance_s;
  logic fin_s;
  logic last_s;

  assign last_s = (index_r == IDX_LAST) || (bus.x && stop_r);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort only acts while a candidate is in flight
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_nxt_s = DRIVE;
        else           state_nxt_s = IDLE;
      end
      DRIVE: begin
        if (bus.abort)           state_nxt_s = FIN;
        else if (CHECK_LAT == 1) state_nxt_s = SAMPLE;
        else                     state_nxt_s = WAIT;
      end
      WAIT: begin
        if (bus.abort)          state_nxt_s = FIN;
        else if (lat_r == 2'd1) state_nxt_s = SAMPLE;
        else                    state_nxt_s = WAIT;
      end
      SAMPLE: begin
        if (bus.abort)   state_nxt_s = FIN;
        else if (last_s) state_nxt_s = FIN;
        else             state_nxt_s = DRIVE;
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath control decode
  always_comb begin
    clear_s   = 1'b0;
    drive_s   = 1'b0;
    wait_s    = 1'b0;
    hit_s     = 1'b0;
    advance_s = 1'b0;
    case (state_r)
      IDLE:   clear_s = bus.start;
      DRIVE:  drive_s = 1'b1;
      WAIT:   wait_s  = 1'b1;
      SAMPLE: begin
        hit_s     = bus.x && !bus.abort;
        advance_s = (state_nxt_s == DRIVE);
      end
      default: clear_s = 1'b0;
    endcase
    fin_s = (state_nxt_s == FIN);
  end

  // Index, latency counter, candidate outputs and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      index_r <= {IW{1'b0}};
      lat_r   <= 2'd0;
      stop_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      found_r <= 1'b0;
      first_r <= {IW{1'b0}};
      count_r <= {(IW+1){1'b0}};
      v11_r   <= {W11{1'b0}};
      v16_r   <= {W16{1'b0}};
      v27_r   <= {W27{1'b0}};
    end else begin
      done_r <= fin_s;
      if (clear_s) begin
        index_r <= {IW{1'b0}};
        found_r <= 1'b0;
        first_r <= {IW{1'b0}};
        count_r <= {(IW+1){1'b0}};
        stop_r  <= bus.stop_on_first;
        busy_r  <= 1'b1;
      end else if (fin_s) begin
        busy_r <= 1'b0;
      end
      if (drive_s) begin
        {v27_r, v16_r, v11_r} <= index_r;
        lat_r <= LAT_LOAD;
      end
      if (wait_s) begin
        lat_r <= lat_r - 2'd1;
      end
      if (hit_s) begin
        count_r <= count_r + CNT_ONE;
        if (!found_r) begin
          found_r <= 1'b1;
          first_r <= index_r;
        end
      end
      if (advance_s) begin
        index_r <= index_r + IDX_ONE;
      end
    end
  end

  assign bus.var_11    = v11_r;
  assign bus.var_16    = v16_r;
  assign bus.var_27    = v27_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.found     = found_r;
  assign bus.first_idx = first_r;
  assign bus.sol_count = count_r;
endmodule

// File: tb/tb_split_6_enum.sv
// Bench for split_6_enum: full-width sweeps against a behavioural checker,
// a reduced-width CHECK_LAT=3 instance for table, abort, reset and random runs.
module tb_split_6_enum;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  int n_checks = 0;
  int n_fail = 0;
  int mode_c = 0;
  logic hit_tab [0:511];
  int ca, ba, ea, cb, bb, eb;

  split_6_enum_if #(.W11(4), .W16(4), .W27(7)) if_a ();
  split_6_enum_if #(.W11(4), .W16(4), .W27(7)) if_b ();
  split_6_enum_if #(.W11(4), .W16(4), .W27(1)) if_c ();

  split_6_enum #(.W11(4), .W16(4), .W27(7), .CHECK_LAT(1)) dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
  split_6_enum #(.W11(4), .W16(4), .W27(7), .CHECK_LAT(1)) dut_b (.clk(clk), .rst(rst_b), .bus(if_b));
  split_6_enum #(.W11(4), .W16(4), .W27(1), .CHECK_LAT(3)) dut_c (.clk(clk), .rst(rst_c), .bus(if_c));

  // Reference checker: var_11 nonzero and all three fields numerically equal
  function automatic logic chk(input int a, input int b, input int c);
    return (a != 0) && (a == b) && (c == a);
  endfunction

  logic [8:0] idx_c;
  assign idx_c = {if_c.var_27, if_c.var_16, if_c.var_11};
  assign if_a.x = chk(int'(if_a.var_11), int'(if_a.var_16), int'(if_a.var_27));
  assign if_b.x = 1'b0;
  always_comb begin
    case (mode_c)
      1:       if_c.x = 1'b1;
      2:       if_c.x = chk(int'(if_c.var_11), int'(if_c.var_16), int'(if_c.var_27));
      3:       if_c.x = hit_tab[idx_c];
      default: if_c.x = 1'b0;
    endcase
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic measure_a(input int limit, output int cyc, output int bcnt, output int early);
    cyc = 0; bcnt = 0; early = 0;
    while (cyc < limit) begin
      if (if_a.busy) bcnt++;
      if (if_a.done) early++;
      @(negedge clk);
      cyc++;
      if (if_a.done) break;
    end
  endtask

  task automatic measure_b(input int limit, output int cyc, output int bcnt, output int early);
    cyc = 0; bcnt = 0; early = 0;
    while (cyc < limit) begin
      if (if_b.busy) bcnt++;
      if (if_b.done) early++;
      @(negedge clk);
      cyc++;
      if (if_b.done) break;
    end
  endtask

  task automatic measure_c(input int limit, output int cyc, output int bcnt, output int early);
    cyc = 0; bcnt = 0; early = 0;
    while (cyc < limit) begin
      if (if_c.busy) bcnt++;
      if (if_c.done) early++;
      @(negedge clk);
      cyc++;
      if (if_c.done) break;
    end
  endtask

  task automatic run_c(input string nm, input int mode, input logic stop, input logic ef,
                       input int efirst, input int ecount, input int ecyc);
    int cyc, bcnt, early;
    mode_c = mode;
    @(negedge clk);
    if_c.stop_on_first = stop;
    if_c.start = 1'b1;
    @(negedge clk);
    if_c.start = 1'b0;
    measure_c(3000, cyc, bcnt, early);
    check({nm, "_done"}, {31'd0, if_c.done}, 32'd1);
    check({nm, "_cycles"}, cyc, ecyc);
    check({nm, "_busy_cycles"}, bcnt, ecyc);
    check({nm, "_early_done"}, early, 32'd0);
    check({nm, "_found"}, {31'd0, if_c.found}, {31'd0, ef});
    check({nm, "_first"}, {23'd0, if_c.first_idx}, efirst);
    check({nm, "_count"}, {22'd0, if_c.sol_count}, ecount);
    @(negedge clk);
    check({nm, "_done_pulse"}, {31'd0, if_c.done}, 32'd0);
    check({nm, "_busy_after"}, {31'd0, if_c.busy}, 32'd0);
  endtask

  typedef struct {
    string name;
    int    mode;
    logic  stop;
    logic  ef;
    int    efirst;
    int    ecount;
    int    ecyc;
  } vec_t;

  // Watchdog in case a sweep never terminates
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [4];
    int exp_cnt, exp_first, n, dcnt, bcnt;
    tbl[0] = '{"c_x1_stop",  1, 1'b1, 1'b1, 0,   1,   4};
    tbl[1] = '{"c_x1_full",  1, 1'b0, 1'b1, 0,   512, 2048};
    tbl[2] = '{"c_chk_stop", 2, 1'b1, 1'b1, 273, 1,   1096};
    tbl[3] = '{"c_x0_full",  0, 1'b0, 1'b0, 0,   0,   2048};

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.start = 1'b0; if_a.stop_on_first = 1'b0; if_a.abort = 1'b0;
    if_b.start = 1'b0; if_b.stop_on_first = 1'b0; if_b.abort = 1'b0;
    if_c.start = 1'b0; if_c.stop_on_first = 1'b0; if_c.abort = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    check("rst_busy_a", {31'd0, if_a.busy}, 32'd0);
    check("rst_done_a", {31'd0, if_a.done}, 32'd0);
    check("rst_found_a", {31'd0, if_a.found}, 32'd0);
    check("rst_first_a", {17'd0, if_a.first_idx}, 32'd0);
    check("rst_count_a", {16'd0, if_a.sol_count}, 32'd0);
    check("rst_vars_a", {17'd0, if_a.var_27, if_a.var_16, if_a.var_11}, 32'd0);
    check("rst_busy_c", {31'd0, if_c.busy}, 32'd0);
    check("rst_count_c", {22'd0, if_c.sol_count}, 32'd0);

    // Full width, stop at first hit
    @(negedge clk);
    if_a.stop_on_first = 1'b1;
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    measure_a(1000, ca, ba, ea);
    check("a_stop_done", {31'd0, if_a.done}, 32'd1);
    check("a_stop_cycles", ca, 32'd548);
    check("a_stop_busy", ba, 32'd548);
    check("a_stop_found", {31'd0, if_a.found}, 32'd1);
    check("a_stop_first", {17'd0, if_a.first_idx}, 32'd273);
    check("a_stop_count", {16'd0, if_a.sol_count}, 32'd1);
    check("a_stop_var27", {25'd0, if_a.var_27}, 32'd1);
    check("a_stop_var16", {28'd0, if_a.var_16}, 32'd1);
    check("a_stop_var11", {28'd0, if_a.var_11}, 32'd1);
    @(negedge clk);
    check("a_stop_done_pulse", {31'd0, if_a.done}, 32'd0);

    // Full sweeps in parallel: A against the checker, B with x tied low
    exp_cnt = 0; exp_first = -1;
    for (int i = 0; i < 32768; i++) begin
      if (chk(i % 16, (i / 16) % 16, i / 256)) begin
        exp_cnt++;
        if (exp_first < 0) exp_first = i;
      end
    end
    @(negedge clk);
    if_a.stop_on_first = 1'b0; if_b.stop_on_first = 1'b0;
    if_a.start = 1'b1; if_b.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0; if_b.start = 1'b0;
    fork
      measure_a(70000, ca, ba, ea);
      measure_b(70000, cb, bb, eb);
    join
    check("a_full_done", {31'd0, if_a.done}, 32'd1);
    check("a_full_cycles", ca, 32'd65536);
    check("a_full_busy", ba, 32'd65536);
    check("a_full_early_done", ea, 32'd0);
    check("a_full_found", {31'd0, if_a.found}, 32'd1);
    check("a_full_first", {17'd0, if_a.first_idx}, exp_first);
    check("a_full_count", {16'd0, if_a.sol_count}, exp_cnt);
    check("b_full_done", {31'd0, if_b.done}, 32'd1);
    check("b_full_cycles", cb, 32'd65536);
    check("b_full_found", {31'd0, if_b.found}, 32'd0);
    check("b_full_count", {16'd0, if_b.sol_count}, 32'd0);
    check("b_full_first", {17'd0, if_b.first_idx}, 32'd0);
    check("b_full_var27", {25'd0, if_b.var_27}, 32'd127);
    check("b_full_var16", {28'd0, if_b.var_16}, 32'd15);
    check("b_full_var11", {28'd0, if_b.var_11}, 32'd15);
    repeat (10) @(negedge clk);
    check("a_hold_found", {31'd0, if_a.found}, 32'd1);
    check("a_hold_first", {17'd0, if_a.first_idx}, exp_first);
    check("a_hold_busy", {31'd0, if_a.busy}, 32'd0);
    check("b_hold_done", {31'd0, if_b.done}, 32'd0);

    for (int t = 0; t < 4; t++) begin
      run_c(tbl[t].name, tbl[t].mode, tbl[t].stop, tbl[t].ef, tbl[t].efirst, tbl[t].ecount, tbl[t].ecyc);
    end

    // Abort while index 5 waits on the checker
    mode_c = 1;
    @(negedge clk);
    if_c.stop_on_first = 1'b0;
    if_c.start = 1'b1;
    @(negedge clk);
    if_c.start = 1'b0;
    n = 0;
    while (idx_c != 9'd5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_idx5", {23'd0, idx_c}, 32'd5);
    if_c.abort = 1'b1;
    @(negedge clk);
    if_c.abort = 1'b0;
    check("abort_done", {31'd0, if_c.done}, 32'd1);
    check("abort_busy", {31'd0, if_c.busy}, 32'd0);
    check("abort_count", {22'd0, if_c.sol_count}, 32'd5);
    check("abort_first", {23'd0, if_c.first_idx}, 32'd0);
    if_c.start = 1'b1;
    @(negedge clk);
    if_c.start = 1'b0;
    check("fin_start_ignored_busy", {31'd0, if_c.busy}, 32'd0);
    check("fin_done_pulse", {31'd0, if_c.done}, 32'd0);
    check("fin_count_held", {22'd0, if_c.sol_count}, 32'd5);

    // start and abort together in IDLE: start wins
    if_c.stop_on_first = 1'b1;
    if_c.start = 1'b1;
    if_c.abort = 1'b1;
    @(negedge clk);
    if_c.start = 1'b0;
    if_c.abort = 1'b0;
    check("start_abort_busy", {31'd0, if_c.busy}, 32'd1);
    check("start_abort_cleared", {22'd0, if_c.sol_count}, 32'd0);
    measure_c(100, ca, ba, ea);
    check("start_abort_cycles", ca, 32'd4);
    check("start_abort_count", {22'd0, if_c.sol_count}, 32'd1);
    check("start_abort_first", {23'd0, if_c.first_idx}, 32'd0);

    // Reset in the middle of a sweep
    @(negedge clk);
    if_c.stop_on_first = 1'b0;
    if_c.start = 1'b1;
    @(negedge clk);
    if_c.start = 1'b0;
    n = 0;
    while (idx_c != 9'd100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_idx100", {23'd0, idx_c}, 32'd100);
    rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0;
    check("mid_rst_busy", {31'd0, if_c.busy}, 32'd0);
    check("mid_rst_done", {31'd0, if_c.done}, 32'd0);
    check("mid_rst_found", {31'd0, if_c.found}, 32'd0);
    check("mid_rst_count", {22'd0, if_c.sol_count}, 32'd0);
    check("mid_rst_vars", {23'd0, idx_c}, 32'd0);
    dcnt = 0; bcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (if_c.done) dcnt++;
      if (if_c.busy) bcnt++;
    end
    check("mid_rst_no_done", dcnt, 32'd0);
    check("mid_rst_stays_idle", bcnt, 32'd0);
    run_c("restart", 1, 1'b1, 1'b1, 0, 1, 4);

    // Random hit tables against a sequential-scan model
    for (int r = 0; r < 3; r++) begin
      int rc, rf, rl;
      logic rs;
      for (int i = 0; i < 512; i++) hit_tab[i] = ($urandom_range(0, 127) == 0);
      rs = 1'($urandom_range(0, 1));
      rc = 0; rf = -1; rl = 511;
      for (int i = 0; i < 512; i++) begin
        if (hit_tab[i]) begin
          rc++;
          if (rf < 0) rf = i;
          if (rs) begin
            rl = i;
            break;
          end
        end
      end
      run_c($sformatf("rand%0d", r), 3, rs, (rc > 0), (rf < 0) ? 0 : rf, rc, 4 * (rl + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
